// File: rtl/fft_addr_gen_pkg.sv
// Shared definitions for the radix-2 DIT FFT address sequencer.
// State encodings and default geometry/latency live here so every file agrees on them.
package fft_addr_gen_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_READ  = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

  // Read-to-write latency: twiddle table, RAM read and butterfly arithmetic.
  localparam int TWIDDLE_LAT  = 4;
  localparam int RAM_RD_LAT   = 1;
  localparam int BFLY_LAT     = 2;
  localparam int PIPE_LAT_DEF = TWIDDLE_LAT + RAM_RD_LAT + BFLY_LAT;

  localparam int BW_FFTP_DEF = 4;

endpackage

// File: rtl/fft_addr_gen_if.sv
// Bus between the FFT address sequencer (master) and the RAM/twiddle/butterfly datapath (slave).
interface fft_addr_gen_if #(
  parameter int bw_fftp = 4
);
  // RdEn qualifies RdAddrA/RdAddrB/Theta and WrEn qualifies WrAddrA/WrAddrB in the same
  // cycle; there is no ready/backpressure, the global ClockEn is the only stall.
  logic               Start;
  logic               Busy;
  logic               Done;
  logic [bw_fftp-1:0] Stage;
  logic               RdEn;
  logic [bw_fftp-1:0] RdAddrA;
  logic [bw_fftp-1:0] RdAddrB;
  logic [bw_fftp-1:0] Theta;
  logic               WrEn;
  logic [bw_fftp-1:0] WrAddrA;
  logic [bw_fftp-1:0] WrAddrB;

  modport master (
    input  Start,
    output Busy, Done, Stage, RdEn, RdAddrA, RdAddrB, Theta, WrEn, WrAddrA, WrAddrB
  );

  modport slave (
    output Start,
    input  Busy, Done, Stage, RdEn, RdAddrA, RdAddrB, Theta, WrEn, WrAddrA, WrAddrB
  );

endinterface

// File: rtl/fft_addr_gen_delay.sv
// Enabled shift-register delay line (DelayUnit): dout is din from 'delay' enabled cycles ago.
module fft_addr_gen_delay #(
  parameter int w_data = 9,
  parameter int delay  = 7
) (
  input  logic              Clock,
  input  logic              Reset,
  input  logic              ClockEn,
  input  logic [w_data-1:0] din,
  output logic [w_data-1:0] dout
);

  logic [delay-1:0][w_data-1:0] line_q;
  logic [delay-1:0][w_data-1:0] line_d;

  always_comb begin
    line_d    = line_q;
    line_d[0] = din;
    for (int i = 1; i < delay; i++) begin
      line_d[i] = line_q[i-1];
    end
  end

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      line_q <= '0;
    end else if (ClockEn) begin
      line_q <= line_d;
    end
  end

  assign dout = line_q[delay-1];

endmodule

// File: rtl/fft_addr_gen.sv
// In-place radix-2 DIT FFT sequencer: butterfly read addresses, twiddle index and delayed
// write-back addresses, stalling at each stage boundary until the butterfly pipeline drains.
module fft_addr_gen
  import fft_addr_gen_pkg::*;
#(
  parameter int bw_fftp  = BW_FFTP_DEF,
  parameter int pipe_lat = PIPE_LAT_DEF
) (
  input  logic           Clock,
  input  logic           Reset,
  input  logic           ClockEn,
  fft_addr_gen_if.master bus,
  output state_e         dbg_state
);

  localparam int JW = bw_fftp - 1;
  localparam int DW = (pipe_lat > 1) ? $clog2(pipe_lat) : 1;
  localparam int WD = 2 * bw_fftp + 1;
  localparam logic [JW-1:0]      J_LAST     = '1;
  localparam logic [bw_fftp-1:0] S_LAST     = bw_fftp'(bw_fftp - 1);
  localparam logic [DW-1:0]      DRAIN_LOAD = DW'(pipe_lat - 1);

  state_e             state_q, state_d;
  logic [JW-1:0]      j_q, j_d;
  logic [bw_fftp-1:0] s_q, s_d;
  logic [DW-1:0]      drain_q, drain_d;

  logic               rd_en_q, rd_en_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic [bw_fftp-1:0] stage_q, stage_d;
  logic [bw_fftp-1:0] rd_addr_a_q, rd_addr_a_d;
  logic [bw_fftp-1:0] rd_addr_b_q, rd_addr_b_d;
  logic [bw_fftp-1:0] theta_q, theta_d;

  logic [bw_fftp-1:0] jx, h, k, grp, addr_a, addr_b, theta;
  logic [WD-1:0]      wr_bus;

  always_comb begin
    state_d = state_q;
    j_d     = j_q;
    s_d     = s_q;
    drain_d = drain_q;
    case (state_q)
      ST_IDLE: begin
        if (bus.Start) begin
          state_d = ST_READ;
          j_d     = '0;
          s_d     = '0;
        end
      end
      ST_READ: begin
        if (j_q == J_LAST) begin
          state_d = ST_DRAIN;
          drain_d = DRAIN_LOAD;
        end else begin
          j_d = j_q + 1'b1;
        end
      end
      ST_DRAIN: begin
        // The last write-back of the stage lands in the cycle the counter reads 0.
        if (drain_q == '0) begin
          if (s_q != S_LAST) begin
            state_d = ST_READ;
            s_d     = s_q + 1'b1;
            j_d     = '0;
          end else begin
            state_d = ST_DONE;
          end
        end else begin
          drain_d = drain_q - 1'b1;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Butterfly j of stage s pairs A and A + 2**s; outputs are computed from next state so
  // they appear registered in the same cycle the FSM enters READ.
  always_comb begin
    jx     = {1'b0, j_d};
    h      = bw_fftp'(1) << s_d;
    k      = jx & (h - bw_fftp'(1));
    grp    = jx >> s_d;
    addr_a = (grp << (s_d + bw_fftp'(1))) | k;
    addr_b = addr_a | h;
    theta  = k << (S_LAST - s_d);
  end

  always_comb begin
    rd_en_d     = (state_d == ST_READ);
    busy_d      = (state_d == ST_READ) || (state_d == ST_DRAIN);
    done_d      = (state_d == ST_DONE);
    stage_d     = s_d;
    rd_addr_a_d = rd_addr_a_q;
    rd_addr_b_d = rd_addr_b_q;
    theta_d     = theta_q;
    if (state_d == ST_READ) begin
      rd_addr_a_d = addr_a;
      rd_addr_b_d = addr_b;
      theta_d     = theta;
    end
  end

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      state_q     <= ST_IDLE;
      j_q         <= '0;
      s_q         <= '0;
      drain_q     <= '0;
      rd_en_q     <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      stage_q     <= '0;
      rd_addr_a_q <= '0;
      rd_addr_b_q <= '0;
      theta_q     <= '0;
    end else if (ClockEn) begin
      state_q     <= state_d;
      j_q         <= j_d;
      s_q         <= s_d;
      drain_q     <= drain_d;
      rd_en_q     <= rd_en_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      stage_q     <= stage_d;
      rd_addr_a_q <= rd_addr_a_d;
      rd_addr_b_q <= rd_addr_b_d;
      theta_q     <= theta_d;
    end
  end

  fft_addr_gen_delay #(
    .w_data (WD),
    .delay  (pipe_lat)
  ) u_delay (
    .Clock   (Clock),
    .Reset   (Reset),
    .ClockEn (ClockEn),
    .din     ({rd_en_q, rd_addr_a_q, rd_addr_b_q}),
    .dout    (wr_bus)
  );

  assign bus.Busy    = busy_q;
  assign bus.Done    = done_q;
  assign bus.Stage   = stage_q;
  assign bus.RdEn    = rd_en_q;
  assign bus.RdAddrA = rd_addr_a_q;
  assign bus.RdAddrB = rd_addr_b_q;
  assign bus.Theta   = theta_q;
  assign bus.WrEn    = wr_bus[WD-1];
  assign bus.WrAddrA = wr_bus[WD-2 -: bw_fftp];
  assign bus.WrAddrB = wr_bus[bw_fftp-1:0];
  assign dbg_state   = state_q;

endmodule

// File: tb/tb_fft_addr_gen.sv
// Directed bench for fft_addr_gen: N=16 with pipe_lat=7, plus a pipe_lat=1 instance.
module tb_fft_addr_gen;
  import fft_addr_gen_pkg::*;

  localparam int BW = 4;

  typedef struct packed {
    logic       busy;
    logic       done;
    logic       rden;
    logic       wren;
    logic [3:0] stage;
    logic [3:0] a;
    logic [3:0] b;
    logic [3:0] th;
    logic [3:0] wa;
    logic [3:0] wb;
  } snap_t;

  // Hand-derived read order per stage (A address and twiddle index for j = 0..7).
  localparam logic [3:0] A_TAB [32] = '{
    4'd0, 4'd2, 4'd4, 4'd6, 4'd8, 4'd10, 4'd12, 4'd14,
    4'd0, 4'd1, 4'd4, 4'd5, 4'd8, 4'd9,  4'd12, 4'd13,
    4'd0, 4'd1, 4'd2, 4'd3, 4'd8, 4'd9,  4'd10, 4'd11,
    4'd0, 4'd1, 4'd2, 4'd3, 4'd4, 4'd5,  4'd6,  4'd7};
  localparam logic [3:0] TH_TAB [32] = '{
    4'd0, 4'd0, 4'd0, 4'd0, 4'd0, 4'd0, 4'd0, 4'd0,
    4'd0, 4'd4, 4'd0, 4'd4, 4'd0, 4'd4, 4'd0, 4'd4,
    4'd0, 4'd2, 4'd4, 4'd6, 4'd0, 4'd2, 4'd4, 4'd6,
    4'd0, 4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 4'd7};

  // ---------------- clock / reset ----------------
  logic   Clock = 1'b0;
  logic   Reset;
  logic   ClockEn;
  state_e dbg0, dbg1;

  always #5 Clock = ~Clock;

  fft_addr_gen_if #(.bw_fftp(BW)) bus0 ();
  fft_addr_gen_if #(.bw_fftp(BW)) bus1 ();

  fft_addr_gen #(.bw_fftp(BW), .pipe_lat(7)) u_dut (
    .Clock     (Clock),
    .Reset     (Reset),
    .ClockEn   (ClockEn),
    .bus       (bus0.master),
    .dbg_state (dbg0)
  );

  fft_addr_gen #(.bw_fftp(BW), .pipe_lat(1)) u_dut1 (
    .Clock     (Clock),
    .Reset     (Reset),
    .ClockEn   (ClockEn),
    .bus       (bus1.master),
    .dbg_state (dbg1)
  );

  // ---------------- scoreboard state ----------------
  int    n_checks = 0;
  int    n_pass   = 0;
  snap_t ref_run [0:127];
  snap_t cur     [0:127];

  // ---------------- driver / helper tasks ----------------
  task automatic step();
    @(posedge Clock);
    #1;
  endtask

  task automatic do_reset();
    Reset      = 1'b1;
    ClockEn    = 1'b1;
    bus0.Start = 1'b0;
    bus1.Start = 1'b0;
    repeat (2) step();
    Reset = 1'b0;
    step();
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass = n_pass + 1;
    else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  function automatic snap_t snap0();
    snap_t s;
    s.busy = bus0.Busy;  s.done = bus0.Done;  s.rden = bus0.RdEn;  s.wren = bus0.WrEn;
    s.stage = bus0.Stage; s.a = bus0.RdAddrA; s.b = bus0.RdAddrB; s.th = bus0.Theta;
    s.wa = bus0.WrAddrA; s.wb = bus0.WrAddrB;
    return s;
  endfunction

  function automatic snap_t snap1();
    snap_t s;
    s.busy = bus1.Busy;  s.done = bus1.Done;  s.rden = bus1.RdEn;  s.wren = bus1.WrEn;
    s.stage = bus1.Stage; s.a = bus1.RdAddrA; s.b = bus1.RdAddrB; s.th = bus1.Theta;
    s.wa = bus1.WrAddrA; s.wb = bus1.WrAddrB;
    return s;
  endfunction

  // ---------------- directed sequence ----------------
  initial begin
    int    bad, cnt, idx, first_wr, en_idx, frozen_bad;
    snap_t prev;

    Reset      = 1'b1;
    ClockEn    = 1'b1;
    bus0.Start = 1'b0;
    bus1.Start = 1'b0;
    #1;
    check("reset_async_outputs", 32'(snap0()), 32'd0);
    do_reset();
    check("reset_outputs", 32'(snap0()), 32'd0);
    check("reset_state", 32'(dbg0), 32'(ST_IDLE));
    check("reset_outputs_pl1", 32'(snap1()), 32'd0);

    // Scenarios 1-3: uninterrupted run, cycle 0 is the Start cycle.
    bus0.Start = 1'b1;
    ref_run[0] = snap0();
    step();
    bus0.Start = 1'b0;
    for (int c = 1; c < 64; c++) begin
      ref_run[c] = snap0();
      if (c < 63) step();
    end
    check("c0_busy", 32'(ref_run[0].busy), 32'd0);
    check("c1_addr_a", 32'(ref_run[1].a), 32'd0);
    check("c1_addr_b", 32'(ref_run[1].b), 32'd1);
    check("c1_theta", 32'(ref_run[1].th), 32'd0);
    check("c2_addr_a", 32'(ref_run[2].a), 32'd2);
    check("c2_addr_b", 32'(ref_run[2].b), 32'd3);
    check("c17_ab_theta", {20'd0, ref_run[17].a, ref_run[17].b, ref_run[17].th},
          {20'd0, 4'd1, 4'd3, 4'd4});
    check("c47_ab_theta_stage",
          {16'd0, ref_run[47].a, ref_run[47].b, ref_run[47].th, ref_run[47].stage},
          {16'd0, 4'd1, 4'd9, 4'd1, 4'd3});

    bad = 0;
    for (int c = 1; c < 64; c++) begin
      logic exp_rd;
      exp_rd = 1'b0;
      for (int s = 0; s < 4; s++) if (c >= 1 + s * 15 && c <= 8 + s * 15) exp_rd = 1'b1;
      if (ref_run[c].rden !== exp_rd) bad++;
      if (ref_run[c].busy !== ((c >= 1 && c <= 60) ? 1'b1 : 1'b0)) bad++;
      if (ref_run[c].done !== ((c == 61) ? 1'b1 : 1'b0)) bad++;
    end
    check("rden_busy_done_timing", 32'(bad), 32'd0);

    bad = 0;
    idx = 0;
    for (int c = 1; c < 64; c++) begin
      if (ref_run[c].rden === 1'b1) begin
        if (idx < 32) begin
          if (ref_run[c].a !== A_TAB[idx]) bad++;
          if (ref_run[c].b !== (A_TAB[idx] | 4'(1 << (idx / 8)))) bad++;
          if (ref_run[c].th !== TH_TAB[idx]) bad++;
          if (ref_run[c].stage !== 4'(idx / 8)) bad++;
        end
        idx++;
      end
    end
    check("read_count", 32'(idx), 32'd32);
    check("read_sequence", 32'(bad), 32'd0);

    bad = 0;
    cnt = 0;
    first_wr = -1;
    for (int c = 1; c < 64; c++) begin
      if (ref_run[c].wren === 1'b1) begin
        cnt++;
        if (first_wr < 0) first_wr = c;
        if (c < 8 || ref_run[c-7].rden !== 1'b1 || ref_run[c].wa !== ref_run[c-7].a ||
            ref_run[c].wb !== ref_run[c-7].b) bad++;
      end
    end
    check("first_wren_cycle", 32'(first_wr), 32'd8);
    check("wren_count", 32'(cnt), 32'd32);
    check("wr_addr_delay", 32'(bad), 32'd0);
    check("stage_edge_c15_c16", {29'd0, ref_run[15].wren, ref_run[15].rden, ref_run[16].rden},
          {29'd0, 1'b1, 1'b0, 1'b1});

    // Scenario 4: ClockEn toggled; compare per enabled cycle against the run above.
    do_reset();
    bus0.Start = 1'b1;
    step();
    bus0.Start = 1'b0;
    en_idx = 1;
    cur[1] = snap0();
    prev = cur[1];
    frozen_bad = 0;
    for (int it = 0; it < 600 && en_idx < 63; it++) begin
      logic ce;
      ce = ($urandom_range(0, 2) != 0);
      ClockEn = ce;
      step();
      if (ce) begin
        en_idx++;
        cur[en_idx] = snap0();
        prev = cur[en_idx];
      end else if (snap0() !== prev) begin
        frozen_bad++;
      end
    end
    ClockEn = 1'b1;
    check("ce_enabled_budget", 32'(en_idx), 32'd63);
    check("ce_low_frozen", 32'(frozen_bad), 32'd0);
    bad = 0;
    for (int c = 1; c <= 63 && c <= en_idx; c++) if (cur[c] !== ref_run[c]) bad++;
    check("ce_sequence", 32'(bad), 32'd0);

    // Scenario 5: reset at cycle 30 aborts the run and drops in-flight writes.
    do_reset();
    bus0.Start = 1'b1;
    step();
    bus0.Start = 1'b0;
    repeat (29) step();
    check("c30_busy_before_reset", 32'(bus0.Busy), 32'd1);
    Reset = 1'b1;
    #1;
    check("midrun_reset_outputs", 32'(snap0()), 32'd0);
    check("midrun_reset_state", 32'(dbg0), 32'(ST_IDLE));
    step();
    Reset = 1'b0;
    cnt = 0;
    for (int c = 0; c < 80; c++) begin
      step();
      if (bus0.Done !== 1'b0 || bus0.WrEn !== 1'b0 || bus0.RdEn !== 1'b0) cnt++;
    end
    check("post_reset_quiet", 32'(cnt), 32'd0);
    bus0.Start = 1'b1;
    step();
    bus0.Start = 1'b0;
    bad = 0;
    for (int c = 1; c <= 20; c++) begin
      if (snap0() !== ref_run[c]) bad++;
      if (c < 20) step();
    end
    check("restart_matches_first_run", 32'(bad), 32'd0);

    // Scenario 6: Start held high across a whole run and into the following IDLE.
    do_reset();
    bus0.Start = 1'b1;
    step();
    bad = 0;
    for (int c = 1; c <= 61; c++) begin
      if (snap0() !== ref_run[c]) bad++;
      step();
    end
    check("start_held_ignored", 32'(bad), 32'd0);
    check("c62_idle", {30'd0, bus0.Busy, bus0.Done}, 32'd0);
    check("c62_state", 32'(dbg0), 32'(ST_IDLE));
    step();
    check("c63_rerun", {24'd0, bus0.RdEn, bus0.Busy, 2'd0, bus0.RdAddrA},
          {24'd0, 1'b1, 1'b1, 2'd0, 4'd0});
    bus0.Start = 1'b0;

    // pipe_lat = 1 instance: next stage reads one cycle after the last write-back.
    do_reset();
    bus1.Start = 1'b1;
    step();
    bus1.Start = 1'b0;
    for (int c = 1; c < 40; c++) begin
      cur[c] = snap1();
      if (c < 39) step();
    end
    check("pl1_c8_rden", 32'(cur[8].rden), 32'd1);
    check("pl1_c9_wr_no_rd", {30'd0, cur[9].wren, cur[9].rden}, {30'd0, 1'b1, 1'b0});
    check("pl1_c10_stage1_read", {20'd0, cur[10].rden, 3'd0, cur[10].stage, cur[10].b},
          {20'd0, 1'b1, 3'd0, 4'd1, 4'd2});
    bad = 0;
    cnt = 0;
    for (int c = 1; c < 40; c++) begin
      if (cur[c].wren === 1'b1) cnt++;
      if (cur[c].done !== ((c == 37) ? 1'b1 : 1'b0)) bad++;
      if (cur[c].busy !== ((c <= 36) ? 1'b1 : 1'b0)) bad++;
    end
    check("pl1_wren_count", 32'(cnt), 32'd32);
    check("pl1_busy_done_timing", 32'(bad), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
